// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-input round-robin mux arbiter.
// Holds the FSM state type, the mux select values and a select-to-grant helper.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic arb_state_t grant_state(input logic sel);
    return (sel == SEL_B) ? GRANT_B : GRANT_A;
  endfunction

endpackage

// File: rtl/mux_2to1if.sv
// Single-bit 2:1 multiplexer used as the arbiter datapath cell.
// sel_in=0 passes a_in, sel_in=1 passes b_in.
module mux_2to1if (
  input  logic a_in,
  input  logic b_in,
  input  logic sel_in,
  output logic y_out
);

  assign y_out = sel_in ? b_in : a_in;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter steering a two-input mux into a registered output stage.
// A burst limit hands the grant to the waiting requester after MAX_BURST beats.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] a_data_in,
  output logic              a_ready_out,
  input  logic              b_valid_in,
  input  logic [DATA_W-1:0] b_data_in,
  output logic              b_ready_out,
  output logic              y_valid_out,
  output logic [DATA_W-1:0] y_data_out,
  input  logic              y_ready_in,
  output logic              sel_out
);

  localparam int               CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  arb_state_t        state;
  logic              prio;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              load_en;
  logic              beat_take;
  logic              cur_sel;
  logic              oth_sel;
  logic              cur_valid;
  logic              oth_valid;
  logic              burst_done;
  logic [DATA_W-1:0] mux_data;

  // Readies depend only on the grant and the output stage, never on the requester valids.
  assign load_en     = !y_valid_out || y_ready_in;
  assign a_ready_out = (state == GRANT_A) && load_en;
  assign b_ready_out = (state == GRANT_B) && load_en;
  assign beat_take   = (a_valid_in && a_ready_out) || (b_valid_in && b_ready_out);

  // Granted (cur) and waiting (oth) sides; only meaningful in the GRANT states.
  assign cur_sel    = (state == GRANT_B) ? SEL_B : SEL_A;
  assign oth_sel    = !cur_sel;
  assign cur_valid  = (cur_sel == SEL_B) ? b_valid_in : a_valid_in;
  assign oth_valid  = (cur_sel == SEL_B) ? a_valid_in : b_valid_in;
  assign cnt_inc    = burst_cnt + CNT_W'(1);
  assign burst_done = cur_valid && (cnt_inc == BURST_LAST);

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux_2to1if u_mux (
      .a_in  (a_data_in[i]),
      .b_in  (b_data_in[i]),
      .sel_in(sel_out),
      .y_out (mux_data[i])
    );
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      prio      <= SEL_A;
      burst_cnt <= '0;
      sel_out   <= SEL_A;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid_in && (!b_valid_in || prio == SEL_A)) begin
            state   <= GRANT_A;
            sel_out <= SEL_A;
          end else if (b_valid_in) begin
            state   <= GRANT_B;
            sel_out <= SEL_B;
          end
        end
        GRANT_A, GRANT_B: begin
          // A stalled output stage freezes the grant and the burst count.
          if (load_en) begin
            if (!cur_valid || burst_done) begin
              burst_cnt <= '0;
            end else begin
              burst_cnt <= cnt_inc;
            end
            if (!cur_valid || (burst_done && oth_valid)) begin
              prio <= oth_sel;
              if (oth_valid) begin
                state   <= grant_state(oth_sel);
                sel_out <= oth_sel;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the data register is reset too, so y_data_out reads zero after reset
  // rather than whatever beat was in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      y_valid_out <= 1'b0;
      y_data_out  <= '0;
    end else if (beat_take) begin
      y_valid_out <= 1'b1;
      y_data_out  <= mux_data;
    end else if (y_ready_in) begin
      y_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: sources drain per-requester queues,
// expected output order is queued up front and checked as beats leave.
module tb_mux2_rr_arbiter;

  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              a_valid_in;
  logic [DATA_W-1:0] a_data_in;
  logic              a_ready_out;
  logic              b_valid_in;
  logic [DATA_W-1:0] b_data_in;
  logic              b_ready_out;
  logic              y_valid_out;
  logic [DATA_W-1:0] y_data_out;
  logic              y_ready_in;
  logic              sel_out;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] a_q[$];
  logic [DATA_W-1:0] b_q[$];
  logic [DATA_W-1:0] exp_q[$];

  mux2_rr_arbiter #(
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .a_valid_in (a_valid_in),
    .a_data_in  (a_data_in),
    .a_ready_out(a_ready_out),
    .b_valid_in (b_valid_in),
    .b_data_in  (b_data_in),
    .b_ready_out(b_ready_out),
    .y_valid_out(y_valid_out),
    .y_data_out (y_data_out),
    .y_ready_in (y_ready_in),
    .sel_out    (sel_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic drive();
    a_valid_in = (a_q.size() != 0);
    a_data_in  = a_valid_in ? a_q[0] : '0;
    b_valid_in = (b_q.size() != 0);
    b_data_in  = b_valid_in ? b_q[0] : '0;
  endtask

  // Called between edges: scores the beat leaving now, advances one clock,
  // retires accepted source beats and returns at the next falling edge.
  task automatic cycle();
    logic              a_fire;
    logic              b_fire;
    logic [DATA_W-1:0] exp_d;
    a_fire = !rst_in && a_valid_in && a_ready_out;
    b_fire = !rst_in && b_valid_in && b_ready_out;
    if (!rst_in && y_valid_out && y_ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra_beat: got %0h, none expected", y_data_out);
      end else begin
        exp_d = exp_q.pop_front();
        if (y_data_out !== exp_d) begin
          failures++;
          $display("FAIL sb_data: got %0h expected %0h", y_data_out, exp_d);
        end
      end
    end
    @(posedge clk_in);
    #1;
    if (a_fire) void'(a_q.pop_front());
    if (b_fire) void'(b_q.pop_front());
    drive();
    @(negedge clk_in);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0 || y_valid_out)
           && n < max_cycles) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || a_q.size() != 0 || b_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d beats still expected, %0d/%0d unsent",
               name, exp_q.size(), a_q.size(), b_q.size());
    end
  endtask

  task automatic do_reset();
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    y_ready_in = 1'b1;
    rst_in     = 1'b1;
    drive();
    cycle();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (y_valid_out !== 1'b0) begin failures++; $display("FAIL reset_y_valid: got %b expected 0", y_valid_out); end
    checks++;
    if (y_data_out !== '0) begin failures++; $display("FAIL reset_y_data: got %0h expected 0", y_data_out); end
    checks++;
    if (sel_out !== 1'b0) begin failures++; $display("FAIL reset_sel: got %b expected 0", sel_out); end
    checks++;
    if (a_ready_out !== 1'b0) begin failures++; $display("FAIL reset_a_ready: got %b expected 0", a_ready_out); end
    checks++;
    if (b_ready_out !== 1'b0) begin failures++; $display("FAIL reset_b_ready: got %b expected 0", b_ready_out); end
  endtask

  task automatic test_a_only();
    logic exp_v;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      a_q.push_back(8'(8'h11 * i));
      exp_q.push_back(8'(8'h11 * i));
    end
    drive();
    checks++;
    if (a_ready_out !== 1'b0) begin failures++; $display("FAIL a_only_idle_ready: got %b expected 0", a_ready_out); end
    for (int i = 1; i <= 6; i++) begin
      cycle();
      exp_v = (i >= 2 && i <= 4);
      checks++;
      if (y_valid_out !== exp_v) begin failures++; $display("FAIL a_only_y_valid c%0d: got %b expected %b", i, y_valid_out, exp_v); end
      checks++;
      if (sel_out !== 1'b0) begin failures++; $display("FAIL a_only_sel c%0d: got %b expected 0", i, sel_out); end
      checks++;
      if (b_ready_out !== 1'b0) begin failures++; $display("FAIL a_only_b_ready c%0d: got %b expected 0", i, b_ready_out); end
    end
    drain("a_only", 20);
  endtask

  task automatic test_both_stream();
    logic exp_s;
    do_reset();
    for (int i = 0; i < 8; i++) a_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) b_q.push_back(8'(8'hB0 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hB0 + i));
    for (int i = 4; i < 8; i++) exp_q.push_back(8'(8'hA0 + i));
    drive();
    for (int i = 1; i <= 13; i++) begin
      cycle();
      exp_s = (i >= 5 && i <= 8);
      checks++;
      if (sel_out !== exp_s) begin failures++; $display("FAIL both_sel c%0d: got %b expected %b", i, sel_out, exp_s); end
      if (i >= 2) begin
        checks++;
        if (y_valid_out !== 1'b1) begin failures++; $display("FAIL both_no_bubble c%0d: got %b expected 1", i, y_valid_out); end
      end
    end
    drain("both", 20);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 6; i++) a_q.push_back(8'(8'hC0 + i));
    b_q.push_back(8'hD0);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hC0 + i));
    exp_q.push_back(8'hD0);
    exp_q.push_back(8'hC4);
    exp_q.push_back(8'hC5);
    drive();
    for (int i = 0; i < 3; i++) cycle();
    y_ready_in = 1'b0;
    #1;
    checks++;
    if (a_ready_out !== 1'b0 || b_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_drop: got a=%b b=%b expected 0 0", a_ready_out, b_ready_out);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++;
      if (y_valid_out !== 1'b1 || y_data_out !== 8'hC1) begin
        failures++;
        $display("FAIL bp_hold c%0d: got v=%b d=%0h expected v=1 d=c1", i, y_valid_out, y_data_out);
      end
      checks++;
      if (a_ready_out !== 1'b0 || b_ready_out !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready c%0d: got a=%b b=%b expected 0 0", i, a_ready_out, b_ready_out);
      end
    end
    y_ready_in = 1'b1;
    #1;
    checks++;
    if (a_ready_out !== 1'b1) begin failures++; $display("FAIL bp_resume_ready: got %b expected 1", a_ready_out); end
    cycle();
    checks++;
    if (y_data_out !== 8'hC2) begin failures++; $display("FAIL bp_resume_data: got %0h expected c2", y_data_out); end
    drain("bp", 30);
  endtask

  task automatic test_a_drop();
    do_reset();
    a_q.push_back(8'hE0);
    a_q.push_back(8'hE1);
    for (int i = 0; i < 6; i++) b_q.push_back(8'(8'hF0 + i));
    exp_q.push_back(8'hE0);
    exp_q.push_back(8'hE1);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hF0 + i));
    for (int i = 2; i < 6; i++) exp_q.push_back(8'(8'hE0 + i));
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hF5);
    drive();
    for (int i = 1; i <= 3; i++) cycle();
    checks++;
    if (sel_out !== 1'b0) begin failures++; $display("FAIL drop_sel_before: got %b expected 0", sel_out); end
    cycle();
    checks++;
    if (sel_out !== 1'b1) begin failures++; $display("FAIL drop_sel_switch: got %b expected 1", sel_out); end
    checks++;
    if (b_ready_out !== 1'b1) begin failures++; $display("FAIL drop_b_ready: got %b expected 1", b_ready_out); end
    for (int i = 2; i < 6; i++) a_q.push_back(8'(8'hE0 + i));
    drive();
    drain("drop", 40);
  endtask

  task automatic test_a_max();
    do_reset();
    for (int i = 0; i < 10; i++) a_q.push_back(8'(8'h40 + i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    drive();
    for (int i = 1; i <= 13; i++) begin
      cycle();
      if (i == 7) begin
        b_q.push_back(8'h5A);
        drive();
      end
      if (i >= 2 && i <= 10) begin
        checks++;
        if (y_valid_out !== 1'b1) begin failures++; $display("FAIL max_stream c%0d: got %b expected 1", i, y_valid_out); end
      end
      if (i <= 8) begin
        checks++;
        if (b_ready_out !== 1'b0) begin failures++; $display("FAIL max_b_wait c%0d: got %b expected 0", i, b_ready_out); end
      end
      if (i == 9) begin
        checks++;
        if (sel_out !== 1'b1) begin failures++; $display("FAIL max_switch_sel: got %b expected 1", sel_out); end
      end
      if (i == 11) begin
        checks++;
        if (y_valid_out !== 1'b0) begin failures++; $display("FAIL max_drop_bubble: got %b expected 0", y_valid_out); end
      end
    end
    drain("max", 20);
  endtask

  task automatic test_reset_mid();
    do_reset();
    y_ready_in = 1'b0;
    b_q.push_back(8'h77);
    b_q.push_back(8'h78);
    drive();
    cycle();
    cycle();
    checks++;
    if (sel_out !== 1'b1 || y_valid_out !== 1'b1) begin
      failures++;
      $display("FAIL rmid_setup: got sel=%b v=%b expected 1 1", sel_out, y_valid_out);
    end
    rst_in = 1'b1;
    a_q.delete();
    b_q.delete();
    exp_q.delete();
    drive();
    cycle();
    rst_in = 1'b0;
    checks++;
    if (y_valid_out !== 1'b0 || y_data_out !== '0) begin
      failures++;
      $display("FAIL rmid_output: got v=%b d=%0h expected v=0 d=0", y_valid_out, y_data_out);
    end
    checks++;
    if (sel_out !== 1'b0 || a_ready_out !== 1'b0 || b_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL rmid_ctrl: got sel=%b a=%b b=%b expected 0 0 0", sel_out, a_ready_out, b_ready_out);
    end
    y_ready_in = 1'b1;
    a_q.push_back(8'h3C);
    b_q.push_back(8'hC3);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    drive();
    cycle();
    checks++;
    if (sel_out !== 1'b0 || a_ready_out !== 1'b1 || b_ready_out !== 1'b0) begin
      failures++;
      $display("FAIL rmid_a_wins: got sel=%b a=%b b=%b expected 0 1 0", sel_out, a_ready_out, b_ready_out);
    end
    drain("rmid", 20);
  endtask

  initial begin
    rst_in     = 1'b1;
    y_ready_in = 1'b1;
    drive();
    @(negedge clk_in);
    test_reset();
    test_a_only();
    test_both_stream();
    test_backpressure();
    test_a_drop();
    test_a_max();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
# mux2_rr_arbiter

Round-robin arbiter and sequencer for the two-input mux datapath. Two requesters present data beats with valid/ready handshakes. The block grants one requester at a time and steers the mux select. It registers the selected beat into a single output stage with its own valid/ready handshake. A burst limit prevents either requester from starving the other.

## Interface
Parameters:
- DATA_W, 8, beat width in bits (≥1)
- MAX_BURST, 4, max consecutive beats from one requester while the other is waiting (≥1)

Ports:
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  synchronous, active-high reset
- a_valid_in  input  1  requester A has a beat
- a_data_in  input  DATA_W  requester A beat
- a_ready_out  output  1  A beat accepted this cycle when high with a_valid_in
- b_valid_in  input  1  requester B has a beat
- b_data_in  input  DATA_W  requester B beat
- b_ready_out  output  1  B beat accepted this cycle when high with b_valid_in
- y_valid_out  output  1  output register holds a beat
- y_data_out  output  DATA_W  output beat
- y_ready_in  input  1  downstream accepts beat
- sel_out  output  1  current grant, 0=A, 1=B; also the mux select

## Operation
- State machine: IDLE, GRANT_A, GRANT_B.
- Registers:
  - prio: 0 = A preferred, 1 = B preferred.
  - burst_cnt: 0..MAX_BURST, width clog2(MAX_BURST+1).
- load_en = !y_valid_out || y_ready_in.
- a_ready_out = (state==GRANT_A) && load_en; b_ready_out = (state==GRANT_B) && load_en. Both are 0 in IDLE.
- IDLE transitions:
  - Only A valid → GRANT_A.
  - Only B valid → GRANT_B.
  - Both valid → grant per prio.
  - Neither valid → stay in IDLE.
- GRANT_X (X granted, Y other):
  - Each accepted X beat increments burst_cnt.
  - If x_valid_in=0 in a cycle: go to GRANT_Y if y_valid_in, else IDLE. burst_cnt←0; prio←Y.
  - If an accepted beat brings burst_cnt to MAX_BURST and y_valid_in=1: go to GRANT_Y, burst_cnt←0, prio←Y.
  - If it reaches MAX_BURST with y_valid_in=0: stay, burst_cnt←0.
- Output register:
  - On an accepted beat, y_data_out←the muxed data and y_valid_out←1.
  - Otherwise, if y_ready_in, y_valid_out←0.
  - y_data_out holds its value when not loading.
- sel_out is registered and equals 1 only in GRANT_B. It holds its last value in IDLE.
- Stall: when y_valid_out=1 and y_ready_in=0, both readies are 0. State and burst_cnt do not change; grant does not switch while stalled.
- Requester data/valid must stay stable until accepted. The block does not check this.

## Timing
- Reset values: state=IDLE, prio=0, burst_cnt=0, sel_out=0, y_valid_out=0, y_data_out=0. a_ready_out and b_ready_out are 0 in the cycle after reset.
- Reset mid-operation discards any beat in the output register; no flush.
- Latency:
  - A beat accepted in cycle N appears on y_data_out in cycle N+1.
  - From IDLE, a request in cycle N is granted in N+1, accepted in N+1 (output empty), and is visible in N+2.
- Throughput: one beat per cycle while granted and downstream ready.
- Grant switch costs no bubble: the last X beat is accepted in cycle N and the first Y beat in cycle N+1.
- Readies combinationally depend on y_ready_in. There are no other combinational input-to-output paths.
- Simultaneous first requests from IDLE after reset: A wins (prio=0).

## Structure
- Shared package/include mux_arb_pkg: state encodings IDLE=2'd0, GRANT_A=2'd1, GRANT_B=2'd2; SEL_A=1'b0, SEL_B=1'b1.
- Datapath uses the existing mux_2to1if, one instance per data bit via generate, with sel_in driven by sel_out.
- FSM, counters and output register are in the top module; no further sub-modules.

## Test plan
- Reset then A only: a_valid_in=1, data 0x11,0x22,0x33, y_ready_in=1. Expect sel_out=0, y_data_out 0x11/0x22/0x33 on consecutive cycles starting 2 cycles after valid rises, b_ready_out never 1.
- Both streaming continuously, MAX_BURST=4, y_ready_in=1. Expect the output pattern A×4, B×4, A×4, with no idle cycle at switches and sel_out toggling every 4 beats.
- Backpressure: y_ready_in=0 for 3 cycles mid-burst. Expect y_data_out held, both readies 0, burst_cnt unchanged; resumes with the next beat the cycle y_ready_in returns to 1.
- A drops valid after 2 beats while B waiting. Expect a switch to GRANT_B next cycle, prio=1, burst_cnt=0; then, with both valid, B keeps the grant for up to 4 beats.
- A alone reaches MAX_BURST with B idle. Expect A to continue uninterrupted; B asserting mid-count waits until A's count hits 4.
- rst_in pulsed while y_valid_out=1 and in GRANT_B. Expect all outputs at reset values next cycle; the held beat is lost and A wins the next simultaneous request.
